sobel_mcu_param: RTL and testbench

Parametrised main control unit for the Sobel edge detector. It sequences one full image, pixel by pixel:
- buffer read
- X and/or Y gradient calculation
- magnitude
- output with backpressure

It tracks row/column position, handles border pixels and flags calculation timeouts. It sits between the AHB slave select, the image buffer, the gradient units and the output stage.

---
 rtl/sobel_pkg.sv | 37 +++
 rtl/sobel_pixel_counter.sv | 48 ++++
 rtl/sobel_mcu_param.sv | 135 +++++++++++++
 tb/tb_sobel_mcu_param.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel main control unit and its pixel counter.
package sobel_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_READ_BUF = 3'd1,
      S_CALC     = 3'd2,
      S_MAG      = 3'd3,
      S_OUTPUT   = 3'd4,
      S_IMG_DONE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      MODE_XY = 2'b00,
      MODE_X  = 2'b01,
      MODE_Y  = 2'b10
   } mode_t;

   // The reserved encoding 2'b11 behaves as X+Y.
   function automatic mode_t decode_mode(input logic [1:0] m);
      return (m == 2'b11) ? MODE_XY : mode_t'(m);
   endfunction

   // Returns {y_needed, x_needed} for a latched mode.
   function automatic logic [1:0] done_needed(input mode_t m);
      case (m)
         MODE_X:  return 2'b01;
         MODE_Y:  return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   function automatic logic is_border(input int r, input int c, input int h, input int w);
      return (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
   endfunction

endpackage

// File: rtl/sobel_pixel_counter.sv
// Row/column position of the pixel being processed, with raster wrap and
// last-pixel / border flags.
module sobel_pixel_counter
   import sobel_pkg::*;
#(
   parameter  int IMG_WIDTH  = 640,
   parameter  int IMG_HEIGHT = 480,
   localparam int CW         = $clog2(IMG_WIDTH),
   localparam int RW         = $clog2(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last,
   output logic          border
);

   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

   logic col_end, row_end;

   assign col_end = (col == COL_MAX);
   assign row_end = (row == ROW_MAX);
   assign last    = col_end & row_end;
   assign border  = is_border(32'(row), 32'(col), IMG_HEIGHT, IMG_WIDTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sobel_mcu_param.sv
// Main control unit of the Sobel edge detector: walks one image pixel by pixel
// through buffer read, gradient calculation, magnitude and a backpressured output.
module sobel_mcu_param
   import sobel_pkg::*;
#(
   parameter  int IMG_WIDTH    = 640,
   parameter  int IMG_HEIGHT   = 480,
   parameter  int BORDER_ZERO  = 1,
   parameter  int CALC_TIMEOUT = 255,
   localparam int RW           = $clog2(IMG_HEIGHT),
   localparam int CW           = $clog2(IMG_WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hsel,
   input  logic          abort,
   input  logic [1:0]    cfg_mode,
   input  logic          data_available,
   input  logic          x_calc_done,
   input  logic          y_calc_done,
   input  logic          out_ready,
   output logic          load_enable,
   output logic          x_start,
   output logic          y_start,
   output logic          mag_enable,
   output logic          output_enable,
   output logic          border,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          busy,
   output logic          convolution_done,
   output logic          timeout_err
);

   localparam int            TW      = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = (CALC_TIMEOUT > 0) ? TW'(CALC_TIMEOUT - 1) : '0;

   state_t        state, nxt;
   mode_t         mode_q;
   logic [1:0]    need;
   logic          x_seen, y_seen, calc_entry;
   logic          grad_done, to_hit, start;
   logic          cnt_clr, cnt_inc, pix_last, pix_border;
   logic [TW-1:0] calc_cnt;

   sobel_pixel_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .row    (row),
      .col    (col),
      .last   (pix_last),
      .border (pix_border)
   );

   // A done seen in an earlier CALC cycle or arriving this cycle both count.
   assign need      = done_needed(mode_q);
   assign grad_done = (~need[0] | x_seen | x_calc_done) & (~need[1] | y_seen | y_calc_done);
   assign to_hit    = (CALC_TIMEOUT != 0) && (calc_cnt == TO_LAST);
   assign start     = (state == S_IDLE) & hsel & ~abort;

   always_comb begin
      nxt     = state;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state)
         S_IDLE: if (hsel) begin
            nxt     = S_READ_BUF;
            cnt_clr = 1'b1;
         end
         S_READ_BUF: if (data_available)
            nxt = ((BORDER_ZERO != 0) && pix_border) ? S_OUTPUT : S_CALC;
         S_CALC: if (grad_done || to_hit)
            nxt = (mode_q == MODE_XY) ? S_MAG : S_OUTPUT;
         S_MAG: nxt = S_OUTPUT;
         S_OUTPUT: if (out_ready) begin
            nxt     = pix_last ? S_IMG_DONE : S_READ_BUF;
            cnt_inc = ~pix_last;
         end
         S_IMG_DONE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (abort) begin
         nxt     = S_IDLE;
         cnt_clr = 1'b0;
         cnt_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         mode_q      <= MODE_XY;
         timeout_err <= 1'b0;
         calc_entry  <= 1'b0;
         x_seen      <= 1'b0;
         y_seen      <= 1'b0;
         calc_cnt    <= '0;
      end else begin
         state      <= nxt;
         calc_entry <= (state == S_READ_BUF) && (nxt == S_CALC);
         if (start) begin
            mode_q      <= decode_mode(cfg_mode);
            timeout_err <= 1'b0;
         end else if ((state == S_CALC) && to_hit && !grad_done && !abort) begin
            timeout_err <= 1'b1;
         end
         if (state == S_CALC) begin
            x_seen   <= x_seen | x_calc_done;
            y_seen   <= y_seen | y_calc_done;
            calc_cnt <= calc_cnt + 1'b1;
         end else begin
            x_seen   <= 1'b0;
            y_seen   <= 1'b0;
            calc_cnt <= '0;
         end
      end
   end

   // Strobes are suppressed in the abort cycle itself.
   assign load_enable      = (state == S_READ_BUF) & data_available & ~abort;
   assign x_start          = calc_entry & need[0] & ~abort;
   assign y_start          = calc_entry & need[1] & ~abort;
   assign mag_enable       = (state == S_MAG) & ~abort;
   assign output_enable    = (state == S_OUTPUT) & ~abort;
   assign convolution_done = (state == S_IMG_DONE) & ~abort;
   assign busy             = (state != S_IDLE);
   // Gated by busy so the idle/reset counters at (0,0) do not flag a border.
   assign border           = busy & pix_border;

endmodule

// File: tb/tb_sobel_mcu_param.sv
// Randomized scoreboard bench for sobel_mcu_param on a 4x3 image with a 4-cycle timeout.
module tb_sobel_mcu_param;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int TO    = 4;
   localparam int NEVER = 99;

   typedef struct {int r; int c; int b; int oe;} pix_t;
   typedef struct {int npix; int nx; int ny; int nmag; int tmo; int cycles;} img_t;

   logic       clk, rst, hsel, abort;
   logic [1:0] cfg_mode;
   logic       data_available, x_calc_done, y_calc_done, out_ready;
   logic       load_enable, x_start, y_start, mag_enable, output_enable, border;
   logic [1:0] row, col;
   logic       busy, convolution_done, timeout_err;

   sobel_mcu_param #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER_ZERO(1), .CALC_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .hsel(hsel), .abort(abort), .cfg_mode(cfg_mode),
      .data_available(data_available), .x_calc_done(x_calc_done),
      .y_calc_done(y_calc_done), .out_ready(out_ready),
      .load_enable(load_enable), .x_start(x_start), .y_start(y_start),
      .mag_enable(mag_enable), .output_enable(output_enable), .border(border),
      .row(row), .col(col), .busy(busy), .convolution_done(convolution_done),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0, n_fail = 0;
   int   da_pct = 100, rdy_pct = 100;
   bit   hold_req = 0;
   pix_t pix_q[$];
   img_t img_q[$];
   int   x_dly_q[$], y_dly_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: raster order, border bypass, per-pixel calc/mag/timeout and cycle cost.
   task automatic plan_image(input logic [1:0] mode, input int dx0, input int dx1,
                             input int dy0, input int dy1, input bit hold, input bit ideal);
      img_t e;
      pix_t p;
      int   k, cyc, t, calc, mag, extra;
      bit   nx_need, ny_need, to, b;
      int   dx[2], dy[2];
      dx[0] = dx0; dx[1] = dx1; dy[0] = dy0; dy[1] = dy1;
      nx_need = (mode != 2'b10);
      ny_need = (mode != 2'b01);
      e = '{npix: W*H, nx: 0, ny: 0, nmag: 0, tmo: 0, cycles: 0};
      k = 0;
      cyc = 1;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            b = (r == 0) || (r == H-1) || (c == 0) || (c == W-1);
            extra = (hold && r == 1 && c == 1) ? 5 : 0;
            p = '{r: r, c: c, b: int'(b), oe: (extra != 0) ? 6 : 0};
            pix_q.push_back(p);
            if (b) begin
               cyc += 2 + extra;
            end else begin
               t = 0;
               to = 0;
               if (nx_need) begin
                  x_dly_q.push_back(dx[k]);
                  e.nx++;
                  if (dx[k] == NEVER) to = 1; else if (dx[k] > t) t = dx[k];
               end
               if (ny_need) begin
                  y_dly_q.push_back(dy[k]);
                  e.ny++;
                  if (dy[k] == NEVER) to = 1; else if (dy[k] > t) t = dy[k];
               end
               if (t >= TO) to = 1;
               if (to) e.tmo = 1;
               calc = to ? TO : t + 1;
               mag = (nx_need && ny_need) ? 1 : 0;
               e.nmag += mag;
               cyc += 1 + calc + mag + 1 + extra;
               k++;
            end
         end
      end
      e.cycles = ideal ? cyc : -1;
      img_q.push_back(e);
   endtask

   task automatic start_image(input logic [1:0] mode);
      @(posedge clk); #1;
      cfg_mode = mode;
      hsel = 1'b1;
      @(posedge clk); #1;
      hsel = 1'b0;
      cfg_mode = ~mode;
   endtask

   task automatic run_image(input logic [1:0] mode, input int dx0, input int dx1,
                            input int dy0, input int dy1, input bit hold);
      bit ok;
      plan_image(mode, dx0, dx1, dy0, dy1, hold, (da_pct == 100) && (rdy_pct == 100));
      hold_req = hold;
      start_image(mode);
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (convolution_done) ok = 1;
      end
      chk("image_done", int'(ok), 1);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      hold_req = 0;
   endtask

   // Input driver: random availability / readiness, optional 5-cycle stall on pixel (1,1).
   initial begin : drv
      int held;
      held = 0;
      data_available = 1'b1;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!hold_req) held = 0;
         data_available = ($urandom_range(99) < da_pct);
         if (hold_req && output_enable && row == 2'd1 && col == 2'd1 && held < 5) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
         end
      end
   end

   initial begin : x_resp
      int d;
      x_calc_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         x_calc_done = 1'b0;
         if (x_start) begin
            d = (x_dly_q.size() > 0) ? x_dly_q.pop_front() : 0;
            if (d != NEVER) begin
               repeat (d) begin @(posedge clk); #1; end
               x_calc_done = 1'b1;
            end
         end
      end
   end

   initial begin : y_resp
      int d;
      y_calc_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         y_calc_done = 1'b0;
         if (y_start) begin
            d = (y_dly_q.size() > 0) ? y_dly_q.pop_front() : 0;
            if (d != NEVER) begin
               repeat (d) begin @(posedge clk); #1; end
               y_calc_done = 1'b1;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT hands off a pixel or ends an image.
   bit   m_bprev = 0, m_tprev = 0;
   int   m_cyc = 0, m_bcnt = 0, m_nx = 0, m_ny = 0, m_nm = 0, m_nhs = 0, m_oerun = 0, m_st = 0;
   pix_t m_p;
   img_t m_e;
   initial begin : mon
      forever begin
         @(negedge clk);
         m_cyc++;
         if (busy && !m_bprev) begin
            m_bcnt = 0; m_nx = 0; m_ny = 0; m_nm = 0; m_nhs = 0;
            chk("tmo_clear_on_start", int'(timeout_err), 0);
         end
         if (busy) m_bcnt++;
         if (x_start) begin m_nx++; m_st = m_cyc; end
         if (y_start) begin m_ny++; m_st = m_cyc; end
         if (mag_enable) m_nm++;
         if (timeout_err && !m_tprev) chk("tmo_latency", m_cyc - m_st, TO);
         if (output_enable) m_oerun++; else m_oerun = 0;
         if (output_enable && out_ready) begin
            m_nhs++;
            if (pix_q.size() == 0) begin
               chk("unexpected_pixel", 1, 0);
            end else begin
               m_p = pix_q.pop_front();
               chk("pix_row", int'(row), m_p.r);
               chk("pix_col", int'(col), m_p.c);
               chk("pix_border", int'(border), m_p.b);
               if (m_p.oe > 0) chk("oe_hold_cycles", m_oerun, m_p.oe);
            end
            m_oerun = 0;
         end
         if (convolution_done) begin
            if (img_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               m_e = img_q.pop_front();
               chk("handshakes", m_nhs, m_e.npix);
               chk("x_start_cnt", m_nx, m_e.nx);
               chk("y_start_cnt", m_ny, m_e.ny);
               chk("mag_cnt", m_nm, m_e.nmag);
               chk("timeout_err", int'(timeout_err), m_e.tmo);
               if (m_e.cycles >= 0) chk("busy_cycles", m_bcnt, m_e.cycles);
               chk("pix_left", pix_q.size(), 0);
            end
         end
         m_bprev = busy;
         m_tprev = timeout_err;
      end
   end

   task automatic flush_expect();
      pix_q.delete();
      img_q.delete();
      x_dly_q.delete();
      y_dly_q.delete();
   endtask

   initial begin : stim
      int  seen, m, d[4];
      bit  found;
      rst = 1'b1; hsel = 1'b0; abort = 1'b0; cfg_mode = 2'b00;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_oe", int'(output_enable), 0);
      chk("rst_load", int'(load_enable), 0);
      chk("rst_start", int'({x_start, y_start, mag_enable}), 0);
      chk("rst_border", int'(border), 0);
      chk("rst_rowcol", int'({row, col}), 0);
      chk("rst_done_tmo", int'({convolution_done, timeout_err}), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run_image(2'b00, 0, 0, 0, 0, 0);          // X+Y, everything immediate
      run_image(2'b01, 0, 2, 0, 0, 0);          // X only
      run_image(2'b00, 3, 3, 0, 0, 0);          // y done 3 cycles before x
      run_image(2'b00, 0, 0, 0, 0, 1);          // 5-cycle output stall on (1,1)
      run_image(2'b01, NEVER, 0, 0, 0, 0);      // timeout, then cleared on next start
      run_image(2'b00, 0, 0, NEVER, 1, 0);
      run_image(2'b11, 1, 0, 0, 2, 0);          // reserved mode behaves as X+Y

      // Abort while calculating pixel (1,2)
      plan_image(2'b00, 0, NEVER, 0, NEVER, 0, 0);
      start_image(2'b00);
      seen = 0;
      for (int i = 0; i < 500 && seen < 2; i++) begin
         @(negedge clk);
         if (x_start) seen++;
      end
      chk("abort_reached_calc", seen, 2);
      chk("abort_row", int'(row), 1);
      chk("abort_col", int'(col), 2);
      flush_expect();
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_idle", int'(busy), 0);
      repeat (10) @(negedge clk);
      run_image(2'b00, 0, 0, 0, 0, 0);

      // Reset while holding in OUTPUT at (1,1)
      plan_image(2'b10, 0, 0, 0, 0, 1, 0);
      hold_req = 1;
      start_image(2'b10);
      found = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (output_enable && row == 2'd1 && col == 2'd1) found = 1;
      end
      chk("rst_reached_output", int'(found), 1);
      flush_expect();
      @(posedge clk); #1 rst = 1'b1;
      hold_req = 0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_oe", int'(output_enable), 0);
      chk("midrst_rowcol", int'({row, col}), 0);
      @(posedge clk); #1 rst = 1'b0;
      run_image(2'b00, 0, 0, 0, 0, 0);

      // Randomized images
      for (int n = 0; n < 16; n++) begin
         m = $urandom_range(3);
         for (int j = 0; j < 4; j++) begin
            d[j] = $urandom_range(0, 4);
            if (d[j] == 4) d[j] = NEVER;
         end
         da_pct  = ($urandom_range(2) == 0) ? 100 : 40 + $urandom_range(60);
         rdy_pct = ($urandom_range(2) == 0) ? 100 : 40 + $urandom_range(60);
         run_image(m[1:0], d[0], d[1], d[2], d[3], 0);
      end
      da_pct = 100;
      rdy_pct = 100;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
